// File: rtl/nano6502_pkg.sv
// Shared definitions for nano6502 peripherals on the 3-bit register bus.
package nano6502_pkg;

  // Interrupt controller register map
  localparam logic [2:0] IRQ_REG_PENDING = 3'd0;
  localparam logic [2:0] IRQ_REG_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_REG_VECTOR  = 3'd2;
  localparam logic [2:0] IRQ_REG_RAW     = 3'd3;
  localparam logic [2:0] IRQ_REG_MODE    = 3'd4;
  localparam logic [2:0] IRQ_REG_SWSET   = 3'd5;

  // Source index of the timer's idle flag
  localparam int IRQ_SRC_TIMER = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [2:0]         index
);

  // Scan from the top down so the lowest set bit is the last to overwrite
  always_comb begin
    valid = |req;
    index = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller driving the 6502 active-low IRQ line.
module irq_ctrl
  import nano6502_pkg::*;
#(
  parameter int         NUM_SRC  = 8,
  parameter logic [7:0] RST_MODE = 8'h00
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               R_W_n,
  input  logic [2:0]         reg_addr_i,
  input  logic [7:0]         data_i,
  input  logic               irq_cs,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [7:0]         data_o,
  output logic               irq_n_o
);

  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] enable_reg;
  logic [NUM_SRC-1:0] mode_reg;
  logic [NUM_SRC-1:0] src_prev_reg;
  logic               irq_n_reg;

  logic               wr_en;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_mode;
  logic               wr_swset;
  logic [NUM_SRC-1:0] wr_data;

  logic               prio_valid;
  logic [2:0]         prio_index;

  assign wr_en      = irq_cs & ~R_W_n;
  assign wr_pending = wr_en && (reg_addr_i == IRQ_REG_PENDING);
  assign wr_enable  = wr_en && (reg_addr_i == IRQ_REG_ENABLE);
  assign wr_mode    = wr_en && (reg_addr_i == IRQ_REG_MODE);
  assign wr_swset   = wr_en && (reg_addr_i == IRQ_REG_SWSET);
  assign wr_data    = data_i[NUM_SRC-1:0];

  // Per-source pending update. Level bits follow the source; edge bits
  // latch rises and SWSET, and any set beats a same-edge W1C.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      assign pending_next[gi] = mode_reg[gi]
        ? src_i[gi]
        : ((pending_reg[gi] & ~(wr_pending & wr_data[gi]))
           | (src_i[gi] & ~src_prev_reg[gi])
           | (wr_swset & wr_data[gi]));
    end
  endgenerate

  // Register state; mode writes land after this edge, so the old mode
  // decides how pending updates on the write edge itself
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending_reg  <= '0;
      enable_reg   <= '0;
      mode_reg     <= RST_MODE[NUM_SRC-1:0];
      src_prev_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      src_prev_reg <= src_i;
      if (wr_enable) begin
        enable_reg <= wr_data;
      end
      if (wr_mode) begin
        mode_reg <= wr_data;
      end
    end
  end

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio (
    .req   (pending_reg & enable_reg),
    .valid (prio_valid),
    .index (prio_index)
  );

  // IRQ line is registered, one edge behind the masked pending state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_n_reg <= 1'b1;
    end else begin
      irq_n_reg <= ~prio_valid;
    end
  end

  assign irq_n_o = irq_n_reg;

  // Side-effect-free read mux; unused upper bits read zero
  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      IRQ_REG_PENDING: data_o = 8'(pending_reg);
      IRQ_REG_ENABLE:  data_o = 8'(enable_reg);
      IRQ_REG_VECTOR:  data_o = prio_valid ? {1'b1, 4'b0000, prio_index} : 8'h00;
      IRQ_REG_RAW:     data_o = 8'(src_i);
      IRQ_REG_MODE:    data_o = 8'(mode_reg);
      default:         data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: rule-level model plus directed vectors.
module tb_irq_ctrl;

  logic       clk_i;
  logic       rst_n_i;
  logic       R_W_n;
  logic [2:0] reg_addr_i;
  logic [7:0] data_i;
  logic       irq_cs;
  logic [7:0] src_i;
  logic [7:0] data_o;
  logic       irq_n_o;

  int checks;
  int failures;

  irq_ctrl #(
    .NUM_SRC  (8),
    .RST_MODE (8'h00)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .R_W_n      (R_W_n),
    .reg_addr_i (reg_addr_i),
    .data_i     (data_i),
    .irq_cs     (irq_cs),
    .src_i      (src_i),
    .data_o     (data_o),
    .irq_n_o    (irq_n_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  logic [7:0] m_pend, m_en, m_mode, m_prev;
  logic       m_irq_n;

  // Vector as software sees it: 0x80 | lowest active source, or 0
  function automatic logic [7:0] m_vector(input logic [7:0] act);
    for (int s = 0; s < 8; s++) begin
      if (act[s]) return 8'h80 | 8'(s);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_pend;
      3'd1:    return m_en;
      3'd2:    return m_vector(m_pend & m_en);
      3'd3:    return src_i;
      3'd4:    return m_mode;
      default: return 8'h00;
    endcase
  endfunction

  // Apply the source rules one source at a time
  function automatic logic [7:0] m_next_pend(
    input logic [7:0] pend, input logic [7:0] mode, input logic [7:0] prev,
    input logic [7:0] src, input logic wr, input logic [2:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = pend;
    for (int s = 0; s < 8; s++) begin
      if (mode[s]) begin
        r[s] = src[s];
      end else begin
        if (wr && a == 3'd0 && d[s]) r[s] = 1'b0;
        if (src[s] && !prev[s]) r[s] = 1'b1;
        if (wr && a == 3'd5 && d[s]) r[s] = 1'b1;
      end
    end
    return r;
  endfunction

  // Model state advances on the same edges as the design
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_pend  <= 8'h00;
      m_en    <= 8'h00;
      m_mode  <= 8'h00;
      m_prev  <= 8'h00;
      m_irq_n <= 1'b1;
    end else begin
      m_irq_n <= ((m_pend & m_en) == 8'h00);
      m_pend  <= m_next_pend(m_pend, m_mode, m_prev, src_i,
                             irq_cs && !R_W_n, reg_addr_i, data_i);
      m_prev  <= src_i;
      if (irq_cs && !R_W_n && reg_addr_i == 3'd1) m_en <= data_i;
      if (irq_cs && !R_W_n && reg_addr_i == 3'd4) m_mode <= data_i;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      checks++;
      if (irq_n_o !== m_irq_n) begin
        failures++;
        $display("FAIL model_irq_n t=%0t got=%b exp=%b", $time, irq_n_o, m_irq_n);
      end
      checks++;
      if (data_o !== m_read(reg_addr_i)) begin
        failures++;
        $display("FAIL model_data addr=%0d t=%0t got=%02h exp=%02h",
                 reg_addr_i, $time, data_o, m_read(reg_addr_i));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_addr_i = a;
    data_i     = d;
    R_W_n      = 1'b0;
    irq_cs     = 1'b1;
    tick();
    R_W_n      = 1'b1;
    irq_cs     = 1'b0;
    $display("wr addr=%0d data=%02h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name);
    reg_addr_i = a;
    R_W_n      = 1'b1;
    irq_cs     = 1'b0;
    #1;
    checks++;
    if (data_o !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", name, data_o, exp);
    end else begin
      $display("rd  addr=%0d data=%02h (%s)", a, data_o, name);
    end
  endtask

  task automatic chk_irq(input logic exp, input string name);
    checks++;
    if (irq_n_o !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, irq_n_o, exp);
    end else begin
      $display("irq irq_n_o=%b (%s)", irq_n_o, name);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n_i    = 1'b0;
    R_W_n      = 1'b1;
    irq_cs     = 1'b0;
    reg_addr_i = 3'd0;
    data_i     = 8'h00;
    src_i      = 8'h01;
    tick();
    tick();
    rst_n_i = 1'b1;

    // Reset view and the spurious timer edge
    rd(3'd0, 8'h00, "pending_before_clk");
    chk_irq(1'b1, "irq_after_reset");
    tick();
    rd(3'd0, 8'h01, "pending_timer_spurious");
    rd(3'd1, 8'h00, "enable_reset");
    rd(3'd2, 8'h00, "vector_masked");
    rd(3'd3, 8'h01, "raw_src");
    rd(3'd4, 8'h00, "mode_reset");
    rd(3'd6, 8'h00, "reg6_zero");
    wr(3'd0, 8'h01);
    rd(3'd0, 8'h00, "pending_after_w1c");

    // Single-source edge path and latency
    wr(3'd1, 8'h01);
    src_i = 8'h00;
    tick();
    src_i = 8'h01;
    tick();
    rd(3'd0, 8'h01, "pending_after_E0");
    chk_irq(1'b1, "irq_still_high_E0");
    tick();
    chk_irq(1'b0, "irq_low_E1");
    rd(3'd2, 8'h80, "vector_src0");
    wr(3'd0, 8'h01);
    chk_irq(1'b0, "irq_low_at_Ew");
    tick();
    chk_irq(1'b1, "irq_high_Ew1");
    tick();
    tick();
    chk_irq(1'b1, "held_high_no_repend");

    // Priority between two simultaneous sources
    wr(3'd1, 8'hFF);
    src_i = 8'h25;
    tick();
    rd(3'd2, 8'h82, "vector_prio_2");
    wr(3'd0, 8'h04);
    rd(3'd2, 8'h85, "vector_prio_5");
    wr(3'd0, 8'h20);
    rd(3'd2, 8'h00, "vector_none");
    tick();
    chk_irq(1'b1, "irq_high_after_clears");

    // Event beats a same-edge W1C
    src_i = 8'h2D;
    wr(3'd0, 8'h08);
    rd(3'd0, 8'h08, "set_wins_over_w1c");
    wr(3'd0, 8'h08);
    rd(3'd0, 8'h00, "w1c_after_event");

    // Level mode
    src_i = 8'h01;
    wr(3'd4, 8'h10);
    wr(3'd1, 8'h10);
    src_i = 8'h11;
    tick();
    rd(3'd0, 8'h10, "level_follows_src");
    tick();
    chk_irq(1'b0, "level_irq_low");
    wr(3'd0, 8'h10);
    rd(3'd0, 8'h10, "level_ignores_w1c");
    src_i = 8'h01;
    tick();
    rd(3'd0, 8'h00, "level_drops");
    chk_irq(1'b0, "level_irq_lag");
    tick();
    chk_irq(1'b1, "level_irq_high");

    // Software set and asynchronous reset
    wr(3'd4, 8'h00);
    wr(3'd1, 8'h40);
    wr(3'd5, 8'h40);
    chk_irq(1'b1, "swset_irq_one_edge");
    rd(3'd5, 8'h00, "swset_reads_zero");
    rd(3'd0, 8'h40, "swset_pending");
    tick();
    chk_irq(1'b0, "swset_irq_two_edges");
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_irq(1'b1, "async_reset_irq");
    rd(3'd1, 8'h00, "async_reset_enable");
    tick();
    rst_n_i = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller for the nano6502 on the same 3-bit-register peripheral bus as the timer.
- Consumes event sources (bit 0 = timer_idle from the timer block; other bits come from UART, GPIO, etc.), latches them as pending, masks them, and drives the 6502 active-low IRQ input.
- Software reads a priority vector to dispatch, then acknowledges with write-1-to-clear.

Parameters:
- NUM_SRC, 8, number of interrupt sources, 1..8; unused upper register bits read 0.
- RST_MODE, 8'h00, reset value of the per-source mode register (0 = rising-edge, 1 = level).

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous, active-low reset.
- R_W_n  input  1  6502 bus direction, 1 = read, 0 = write.
- reg_addr_i  input  3  register select.
- data_i  input  8  write data.
- irq_cs  input  1  chip select; a write takes effect on every clk_i edge where irq_cs=1 and R_W_n=0.
- src_i  input  NUM_SRC  event sources, synchronous to clk_i; bit 0 = timer_idle.
- data_o  output  8  combinational read data for reg_addr_i.
- irq_n_o  output  1  registered, active-low IRQ to the CPU.

Behaviour:
- Register map:
  - 0 PENDING: read pending[7:0]; write 1s clear edge-mode bits.
  - 1 ENABLE: R/W mask.
  - 2 VECTOR: read-only. bit7 = any (pending&enable); bits2:0 = lowest-index set bit of pending&enable; reads 8'h00 when none.
  - 3 RAW: read-only, current src_i.
  - 4 MODE: R/W.
  - 5 SWSET: write 1s set pending bits of edge-mode sources; reads 0.
  - 6, 7: read 0, writes ignored.
- Reads have no side effects.
- Reset (async): pending=0, enable=0, mode=RST_MODE, src_prev=0, irq_n_o=1.
  - Timer_idle is 1 at reset, but src_prev=0, so a spurious edge can occur. Bit 0 in edge mode therefore pends on the first clock after reset. Software clears it before enabling.
- Edge mode, per bit:
  - pending sets at the clk edge where src_i=1 and src_prev=0. src_prev <= src_i every cycle.
  - A timer expiry or a cancel (idle 0->1) pends bit 0.
  - Event and W1C on the same edge: set wins.
  - SWSET and event on the same edge: set.
  - A held-high source does not re-pend after clear.
- Level mode, per bit: pending <= src_i every cycle. W1C and SWSET are ignored for that bit.
- Mode change: a bit switched edge->level takes src_i on the next edge. A bit switched level->edge keeps its current pending value.
- irq_n_o <= ~|(pending & enable & valid_mask), registered.
  - Latency: src_i rise sampled at edge E0 -> PENDING readable after E0 -> irq_n_o low after E1.
  - Clear at edge Ew -> irq_n_o high after Ew+1.
- Enable change: takes effect on irq_n_o one edge after the write edge.
- Repeated write cycles while irq_cs is held are idempotent for all registers.
- Bits >= NUM_SRC: pending/enable/mode held 0.

Decomposition:
- Shared package (nano6502_pkg): register address constants IRQ_REG_PENDING..IRQ_REG_SWSET, and the source index constant IRQ_SRC_TIMER=0.
- One sub-module, irq_prio_enc: NUM_SRC-bit request in, {valid, index[2:0]} out, lowest index wins. It feeds both VECTOR and the irq_n_o OR-reduce.

Test Plan:
- Reset, then read all registers -> PENDING=0x01 after the first clock (bit 0 edge from timer_idle=1), ENABLE=0x00, VECTOR=0x00 with bit 0 masked, irq_n_o=1. Then write PENDING=0x01 -> reads 0x00.
- ENABLE=0x01; pulse src_i[0] 0->1 at E0 -> PENDING=0x01 after E0, irq_n_o=0 after E1, VECTOR=0x80. Write PENDING=0x01 at Ew -> irq_n_o=1 after Ew+1, and it stays 1 while src_i[0] remains high.
- ENABLE=0xFF; rise src_i[5] and src_i[2] on the same edge -> VECTOR=0x82. Clear bit 2 -> VECTOR=0x85. Clear bit 5 -> VECTOR=0x00, irq_n_o=1.
- W1C of bit 3 on the same edge as a src_i[3] rise -> PENDING bit 3 remains 1.
- MODE=0x10, ENABLE=0x10; hold src_i[4]=1 -> irq_n_o=0. Write PENDING=0x10 -> still 1. Drop src_i -> PENDING bit4=0 next edge, irq_n_o=1 one edge later.
- SWSET=0x40 with ENABLE=0x40 -> irq_n_o=0 two edges later. Assert rst_n_i low mid-operation -> irq_n_o=1 and ENABLE=0 immediately, asynchronously.
